// File: rtl/paper_soccer_pkg.sv
// Shared definitions for the paper-soccer turn controller.
//   - direction encoding (dir_e)
//   - FSM state encoding (plain localparams so legacy code can reuse them)
//   - per-direction x/y step tables, indexed by the 3-bit direction code
package paper_soccer_pkg;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_e;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;
    localparam logic [2:0] S_OVER   = 3'd6;

    // North is toward y=0, east is toward larger x.
    localparam logic signed [1:0] DX_TAB [0:7] =
        '{2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1, -2'sd1, -2'sd1};
    localparam logic signed [1:0] DY_TAB [0:7] =
        '{-2'sd1, -2'sd1, 2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1};

endpackage

// File: rtl/dir_decode.sv
// Combinational direction-to-offset decoder.
// Ports:
//   dir  in  3  direction code (see paper_soccer_pkg::dir_e)
//   dx   out 2  signed x step (-1, 0, +1)
//   dy   out 2  signed y step (-1, 0, +1)
module dir_decode
    import paper_soccer_pkg::*;
(
    input  logic        [2:0] dir,
    output logic signed [1:0] dx,
    output logic signed [1:0] dy
);

    assign dx = DX_TAB[dir];
    assign dy = DY_TAB[dir];

endmodule

// File: rtl/turn_ctrl.sv
// Paper-soccer turn controller: grants turns, validates a move against the
// field bounds, looks up the visited flag of the destination point, marks it,
// and decides bounce / goal / timeout.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       begin (or restart) a game from IDLE/OVER
//   width_in, length_in         field size latched at start
//   p0_dir/_valid, p1_dir/_valid  planner direction and strobe
//   p0_addr, p1_addr            planner board-memory addresses
//   p0_my_turn, p1_my_turn      one-cycle turn grant
//   mem_addr / mem_data         shared board read port (1-cycle latency)
//   mark_we / mark_addr         set visited flag of a point
//   cur_x, cur_y, color         ball position and player to move
//   illegal, game_over, winner, timeout  status
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start
// GRANT    | one-cycle turn pulse to player `color`, timeout counter cleared
// WAIT_DIR | granted player's address on mem_addr, waiting for its dir_valid
// RD       | destination address on mem_addr
// EVAL     | visited flag sampled, ball moved to destination
// UPDATE   | destination marked; goal, bounce or turn change decided
// OVER     | result held until start
module turn_ctrl
    import paper_soccer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  width_in,
    input  logic [7:0]  length_in,
    input  logic [2:0]  p0_dir,
    input  logic        p0_dir_valid,
    input  logic [2:0]  p1_dir,
    input  logic        p1_dir_valid,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p1_addr,
    output logic        p0_my_turn,
    output logic        p1_my_turn,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        mark_we,
    output logic [15:0] mark_addr,
    output logic [7:0]  cur_x,
    output logic [7:0]  cur_y,
    output logic        color,
    output logic        illegal,
    output logic        game_over,
    output logic        winner,
    output logic        timeout
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYC - 1);

    logic [2:0]    state;
    logic [7:0]    width_r, len_r;
    logic [7:0]    dest_x, dest_y;
    logic          vis_r;
    logic [CW-1:0] cnt;

    logic [2:0]        sel_dir;
    logic              sel_valid;
    logic signed [1:0] dx, dy;
    logic signed [8:0] nx, ny;
    logic              oob;
    logic [6:0]        unused_mem_bits;

    assign unused_mem_bits = mem_data[7:1];

    // Only the player to move is listened to.
    assign sel_dir   = color ? p1_dir : p0_dir;
    assign sel_valid = color ? p1_dir_valid : p0_dir_valid;

    dir_decode u_dir_decode (
        .dir (sel_dir),
        .dx  (dx),
        .dy  (dy)
    );

    // 9-bit signed so that stepping off either edge of an 8-bit field is visible.
    assign nx  = $signed({1'b0, cur_x}) + $signed({{7{dx[1]}}, dx});
    assign ny  = $signed({1'b0, cur_y}) + $signed({{7{dy[1]}}, dy});
    assign oob = nx[8] | ny[8]
               | (nx > $signed({1'b0, width_r}))
               | (ny > $signed({1'b0, len_r}));

    assign p0_my_turn = (state == S_GRANT) && !color;
    assign p1_my_turn = (state == S_GRANT) &&  color;
    assign mark_we    = (state == S_UPDATE);
    assign mark_addr  = (state == S_UPDATE) ? {dest_y, dest_x} : 16'd0;

    always_comb begin
        mem_addr = 16'd0;
        case (state)
            S_WAIT:  mem_addr = color ? p1_addr : p0_addr;
            S_RD:    mem_addr = {dest_y, dest_x};
            default: mem_addr = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            width_r   <= 8'd0;
            len_r     <= 8'd0;
            dest_x    <= 8'd0;
            dest_y    <= 8'd0;
            vis_r     <= 1'b0;
            cnt       <= '0;
            cur_x     <= 8'd0;
            cur_y     <= 8'd0;
            color     <= 1'b0;
            illegal   <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        width_r   <= width_in;
                        len_r     <= length_in;
                        cur_x     <= width_in >> 1;
                        cur_y     <= length_in >> 1;
                        color     <= 1'b0;
                        game_over <= 1'b0;
                        timeout   <= 1'b0;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A move on the terminal-count cycle still wins over the timeout.
                    if (sel_valid) begin
                        if (oob) begin
                            illegal <= 1'b1;
                            state   <= S_GRANT;
                        end else begin
                            dest_x <= nx[7:0];
                            dest_y <= ny[7:0];
                            state  <= S_RD;
                        end
                    end else if (cnt == TC_LAST) begin
                        timeout   <= 1'b1;
                        winner    <= ~color;
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RD: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    vis_r <= mem_data[0];
                    cur_x <= dest_x;
                    cur_y <= dest_y;
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (dest_y == 8'd0) begin
                        winner    <= 1'b1;
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else if (dest_y == len_r) begin
                        winner    <= 1'b0;
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        // Landing on a visited point earns another move.
                        if (!vis_r) color <= ~color;
                        state <= S_GRANT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_ctrl.sv
// Self-checking bench for turn_ctrl. The board memory is a bit array owned by
// the stimulus process; the reference model tracks position, turn and visited
// points from the game rules and predicts every observable per move.
module tb_turn_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  width_in = 8'd0, length_in = 8'd0;
    logic [2:0]  p0_dir = 3'd0, p1_dir = 3'd0;
    logic        p0_dir_valid = 1'b0, p1_dir_valid = 1'b0;
    logic [15:0] p0_addr = 16'h1234, p1_addr = 16'hABCD;
    logic        p0_my_turn, p1_my_turn;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = 8'd0;
    logic        mark_we;
    logic [15:0] mark_addr;
    logic [7:0]  cur_x, cur_y;
    logic        color, illegal, game_over, winner, timeout;

    turn_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .width_in(width_in), .length_in(length_in),
        .p0_dir(p0_dir), .p0_dir_valid(p0_dir_valid),
        .p1_dir(p1_dir), .p1_dir_valid(p1_dir_valid),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_my_turn(p0_my_turn), .p1_my_turn(p1_my_turn),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mark_we(mark_we), .mark_addr(mark_addr),
        .cur_x(cur_x), .cur_y(cur_y), .color(color),
        .illegal(illegal), .game_over(game_over), .winner(winner), .timeout(timeout)
    );

    always #5 clk = ~clk;

    bit mem_vis [0:65535];
    bit ref_vis [0:65535];

    // Board memory read port: 1-cycle latency, junk in the upper bits.
    always @(posedge clk) mem_data <= {7'($urandom), mem_vis[mem_addr]};

    int total = 0, bad = 0;
    int dxt [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dyt [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int mx, my, mcol, mW, mL, mwin;
    bit mover;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records board writes, then advances to the next falling edge.
    task automatic tick;
        if (mark_we === 1'b1) mem_vis[mark_addr] = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_board;
        foreach (mem_vis[i]) begin
            mem_vis[i] = 1'b0;
            ref_vis[i] = 1'b0;
        end
    endtask

    task automatic do_start(input int w, input int l);
        width_in = 8'(w);
        length_in = 8'(l);
        start = 1'b1;
        tick;
        start = 1'b0;
        clear_board;
        mW = w; mL = l; mx = w / 2; my = l / 2; mcol = 0; mover = 0;
        chk("start_clears_over", game_over, 0);
        chk("start_clears_timeout", timeout, 0);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (p0_my_turn === 1'b1 || p1_my_turn === 1'b1) begin
                ok = 1;
                break;
            end
            tick;
        end
        if (!ok) begin
            total++;
            bad++;
            $error("FAIL grant_wait observed=none expected=my_turn");
        end
    endtask

    task automatic grant_checks;
        chk("turn_p0", p0_my_turn, mcol == 0);
        chk("turn_p1", p1_my_turn, mcol == 1);
        chk("grant_cur_x", cur_x, mx);
        chk("grant_cur_y", cur_y, my);
        chk("grant_color", color, mcol);
        chk("addr_grant", mem_addr, 0);
    endtask

    task automatic drive_dir(input int d, input bit junk);
        if (mcol == 0) begin
            p0_dir = 3'(d); p0_dir_valid = 1'b1;
            if (junk) begin p1_dir = 3'(d + 4); p1_dir_valid = 1'b1; end
        end else begin
            p1_dir = 3'(d); p1_dir_valid = 1'b1;
            if (junk) begin p0_dir = 3'(d + 4); p0_dir_valid = 1'b1; end
        end
        tick;
        p0_dir_valid = 1'b0;
        p1_dir_valid = 1'b0;
    endtask

    task automatic mv(input int d, input int dly, input bit junk, input bit try_start);
        bit ok, vis;
        int nx, ny, a;
        wait_grant(ok);
        if (!ok) return;
        grant_checks;
        tick;
        chk("turn_pulse", p0_my_turn | p1_my_turn, 0);
        chk("illegal_pulse", illegal, 0);
        chk("addr_wait", mem_addr, (mcol == 1) ? p1_addr : p0_addr);
        for (int i = 0; i < dly - 1; i++) begin
            if (try_start && i == 0) begin
                width_in = 8'd3; length_in = 8'd3; start = 1'b1;
            end
            tick;
            start = 1'b0;
            width_in = 8'(mW); length_in = 8'(mL);
        end
        drive_dir(d, junk);
        nx = mx + dxt[d];
        ny = my + dyt[d];
        if (nx < 0 || nx > mW || ny < 0 || ny > mL) begin
            chk("illegal", illegal, 1);
            chk("ill_cur_x", cur_x, mx);
            chk("ill_cur_y", cur_y, my);
            chk("ill_regrant", (mcol == 1) ? p1_my_turn : p0_my_turn, 1);
            return;
        end
        a = ny * 256 + nx;
        chk("illegal_n", illegal, 0);
        chk("addr_rd", mem_addr, a);
        chk("mark_early", mark_we, 0);
        tick;
        tick;
        chk("mark_we", mark_we, 1);
        chk("mark_addr", mark_addr, a);
        chk("upd_cur_x", cur_x, nx);
        chk("upd_cur_y", cur_y, ny);
        vis = ref_vis[a];
        ref_vis[a] = 1'b1;
        mx = nx; my = ny;
        if (ny == 0) begin mover = 1; mwin = 1; end
        else if (ny == mL) begin mover = 1; mwin = 0; end
        else if (!vis) mcol = 1 - mcol;
        tick;
        if (mover) begin
            chk("game_over", game_over, 1);
            chk("winner", winner, mwin);
            chk("over_no_turn", p0_my_turn | p1_my_turn, 0);
        end else begin
            chk("turn_latency", (mcol == 1) ? p1_my_turn : p0_my_turn, 1);
        end
    endtask

    task automatic do_timeout;
        bit ok;
        wait_grant(ok);
        if (!ok) return;
        grant_checks;
        repeat (TO) tick;
        chk("timeout_early", timeout, 0);
        tick;
        chk("timeout", timeout, 1);
        chk("timeout_winner", winner, 1 - mcol);
        chk("timeout_over", game_over, 1);
        mover = 1;
        mwin = 1 - mcol;
    endtask

    task automatic random_game(input int n);
        for (int i = 0; i < n && !mover; i++)
            mv($urandom_range(0, 7), $urandom_range(1, TO), 1'($urandom_range(0, 1)), 1'b0);
        if (!mover) do_timeout;
        repeat (3) tick;
        chk("over_hold", game_over, 1);
        chk("over_winner_hold", winner, mwin);
    endtask

    initial begin
        bit ok;
        tick;
        tick;
        chk("rst_cur_x", cur_x, 0);
        chk("rst_cur_y", cur_y, 0);
        chk("rst_color", color, 0);
        chk("rst_over", game_over, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_turn", p0_my_turn | p1_my_turn, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        repeat (5) tick;
        chk("idle_no_turn", p0_my_turn | p1_my_turn, 0);
        chk("idle_no_mark", mark_we, 0);

        // Opening move east, bounce on visited, walk west into the wall.
        do_start(8, 10);
        mv(2, 1, 1'b0, 1'b0);
        mem_vis[6 * 256 + 5] = 1'b1;
        ref_vis[6 * 256 + 5] = 1'b1;
        mv(4, 3, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) mv(6, 2 + i, 1'b0, i == 1);
        mv(7, 4, 1'b1, 1'b0);
        random_game(60);

        // Pure timeout.
        do_start(8, 10);
        do_timeout;

        // Move on the terminal-count cycle, then run north into the goal.
        do_start(8, 10);
        mv(0, TO, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) mv(0, 1 + i, 1'b0, 1'b0);

        do_start($urandom_range(2, 30), $urandom_range(2, 30));
        random_game(80);
        do_start($urandom_range(2, 30), $urandom_range(2, 30));
        random_game(80);

        // Reset while the destination read is in flight.
        do_start(8, 10);
        mv(2, 2, 1'b0, 1'b0);
        wait_grant(ok);
        tick;
        drive_dir(4, 1'b0);
        chk("rd_addr_live", mem_addr, 6 * 256 + 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cur_x", cur_x, 0);
        chk("mid_rst_cur_y", cur_y, 0);
        chk("mid_rst_color", color, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_mark", mark_we, 0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("post_rst_mark", mark_we, 0);
        end
        chk("post_rst_turn", p0_my_turn | p1_my_turn, 0);
        do_start(8, 10);
        mv(1, 3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
